// File: rtl/irq_count_unit_pkg.sv
// Shared definitions for the interrupt front-end: controller command codes
// and the request-tracking state type.
package irq_count_unit_pkg;

  localparam logic [1:0] CC_IDLE  = 2'b00;
  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PEND  = 2'b01,
    ST_ACKED = 2'b10
  } req_state_t;

endpackage

// File: rtl/irq_count_unit_sync2.sv
// Two-flop synchronizer with synchronous reset for a single asynchronous level.
module irq_count_unit_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/irq_count_unit.sv
// Interrupt front-end: synchronizes the external request, tracks it until the
// controller acknowledges, and runs the controller-enabled event counter.
module irq_count_unit
  import irq_count_unit_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 9,
  parameter int ACK_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_in,
  input  logic [1:0]       cc_mux,
  input  logic             enable_count,
  input  logic             ackout,
  output logic             eql,
  output logic             cont_eql,
  output logic [CNT_W-1:0] count,
  output logic [ACK_W-1:0] ack_tally,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);

  function automatic logic [ACK_W-1:0] sat_inc(input logic [ACK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic       w_req_sync;
  logic       w_ack;
  req_state_t r_state;
  req_state_t w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [ACK_W-1:0] r_ack_tally;

  irq_count_unit_sync2 u_sync2 (
    .clock (clock),
    .reset (reset),
    .i_d   (req_in),
    .o_q   (w_req_sync)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Re-arming from ACKED needs the synchronized request to drop first,
  // so a request held high is counted only once.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_req_sync) w_state_nxt = ST_PEND;
      ST_PEND: begin
        if (cc_mux == CC_ACKIN && ackout) begin
          w_state_nxt = ST_ACKED;
          w_ack       = 1'b1;
        end
      end
      ST_ACKED: if (!w_req_sync) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)      r_ack_tally <= '0;
    else if (w_ack) r_ack_tally <= sat_inc(r_ack_tally);
  end

  // Clear has priority over increment; the counter parks at TERMINAL.
  always_ff @(posedge clock) begin
    if (reset)                                  r_count <= '0;
    else if (cc_mux == CC_INTR)                 r_count <= '0;
    else if (enable_count && r_count != TERM_C) r_count <= r_count + 1'b1;
  end

  assign eql       = (r_state == ST_PEND);
  assign busy      = (r_state != ST_IDLE);
  assign cont_eql  = (r_count == TERM_C);
  assign count     = r_count;
  assign ack_tally = r_ack_tally;

endmodule

// File: tb/tb_irq_count_unit.sv
// Bench for irq_count_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the request/counter rules.
module tb_irq_count_unit;

  localparam int CNT_W    = 4;
  localparam int TERMINAL = 9;
  localparam int ACK_W    = 8;
  localparam int TALLY_MAX = (1 << ACK_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_in = 1'b0;
  logic [1:0]       cc_mux = 2'b00;
  logic             enable_count = 1'b0;
  logic             ackout = 1'b0;
  logic             eql;
  logic             cont_eql;
  logic [CNT_W-1:0] count;
  logic [ACK_W-1:0] ack_tally;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Model: request history seen through two sample delays, a "waiting for ack"
  // flag, a "served, waiting for release" flag, and plain integer counters.
  bit m_seen1, m_seen2;
  bit m_waiting, m_served;
  int m_cnt, m_tally;

  irq_count_unit #(.CNT_W(CNT_W), .TERMINAL(TERMINAL), .ACK_W(ACK_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_in       (req_in),
    .cc_mux       (cc_mux),
    .enable_count (enable_count),
    .ackout       (ackout),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .count        (count),
    .ack_tally    (ack_tally),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit [1:0] cc, input bit en, input bit ak, input bit rs);
    bit seen;
    if (rs) begin
      m_seen1 = 0; m_seen2 = 0; m_waiting = 0; m_served = 0; m_cnt = 0; m_tally = 0;
      return;
    end
    seen = m_seen2;
    if (m_waiting) begin
      if (cc == 2'b11 && ak) begin
        m_waiting = 0;
        m_served  = 1;
        if (m_tally < TALLY_MAX) m_tally++;
      end
    end else if (m_served) begin
      if (!seen) m_served = 0;
    end else if (seen) begin
      m_waiting = 1;
    end
    m_seen2 = m_seen1;
    m_seen1 = r;
    if (cc == 2'b10) m_cnt = 0;
    else if (en && m_cnt < TERMINAL) m_cnt++;
  endtask

  task automatic step(input bit r, input bit [1:0] cc, input bit en, input bit ak, input bit rs);
    @(negedge clock);
    req_in = r; cc_mux = cc; enable_count = en; ackout = ak; reset = rs;
    @(posedge clock);
    model_edge(r, cc, en, ak, rs);
    #1;
    chk("eql",       32'(eql),       32'(m_waiting));
    chk("busy",      32'(busy),      32'(m_waiting | m_served));
    chk("cont_eql",  32'(cont_eql),  32'(m_cnt == TERMINAL));
    chk("count",     32'(count),     32'(m_cnt));
    chk("ack_tally", 32'(ack_tally), 32'(m_tally));
  endtask

  initial begin
    // Reset then idle
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1);
    chk("rst_eql", 32'(eql), 0);
    chk("rst_cont_eql", 32'(cont_eql), 0);
    chk("rst_count", 32'(count), 0);
    for (int i = 0; i < 5; i++) step(0, 2'b00, 0, 0, 0);
    chk("idle_busy", 32'(busy), 0);

    // Request latency: eql rises two edges after req_in is first sampled
    step(1, 2'b00, 0, 0, 0);
    chk("lat_n", 32'(eql), 0);
    step(1, 2'b00, 0, 0, 0);
    chk("lat_n1", 32'(eql), 0);
    step(1, 2'b00, 0, 0, 0);
    chk("lat_n2", 32'(eql), 1);
    step(1, 2'b11, 0, 0, 0);
    chk("ack_qual_off", 32'(eql), 1);
    step(1, 2'b11, 0, 1, 0);
    chk("ack_eql", 32'(eql), 0);
    chk("ack_tally1", 32'(ack_tally), 1);
    // Held request across and after the ack is not re-counted
    for (int i = 0; i < 4; i++) step(1, 2'b11, 0, 1, 0);
    chk("hold_eql", 32'(eql), 0);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_tally", 32'(ack_tally), 1);
    step(0, 2'b00, 0, 0, 0);
    chk("rel_busy0", 32'(busy), 1);
    step(0, 2'b00, 0, 0, 0);
    chk("rel_busy1", 32'(busy), 1);
    step(0, 2'b00, 0, 0, 0);
    chk("rel_busy2", 32'(busy), 0);

    // Count to terminal and hold
    for (int i = 1; i <= 12; i++) begin
      step(0, 2'b01, 1, 0, 0);
      chk("cnt_step", 32'(count), (i < TERMINAL) ? i : TERMINAL);
      chk("cnt_term", 32'(cont_eql), 32'(i >= TERMINAL));
    end
    step(0, 2'b10, 0, 0, 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_cont", 32'(cont_eql), 0);

    // Clear beats enable
    for (int i = 0; i < 5; i++) step(0, 2'b01, 1, 0, 0);
    chk("pre_clr5", 32'(count), 5);
    step(0, 2'b10, 1, 0, 0);
    chk("clr_vs_en", 32'(count), 0);

    // Mid-operation reset while pending with count 7
    for (int i = 0; i < 7; i++) step(1, 2'b01, 1, 0, 0);
    chk("pre_rst_eql", 32'(eql), 1);
    chk("pre_rst_cnt", 32'(count), 7);
    step(1, 2'b01, 1, 1, 1);
    chk("mrst_eql", 32'(eql), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_tally", 32'(ack_tally), 0);
    step(0, 2'b00, 0, 0, 0);

    // Saturation of the acknowledged-request tally
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 0, 0);
      step(1, 2'b11, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 0);
    end
    chk("tally_sat", 32'(ack_tally), TALLY_MAX);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 0, 0);
    step(1, 2'b11, 0, 1, 0);
    chk("tally_sat_hold", 32'(ack_tally), TALLY_MAX);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit r, en, ak, rs;
      bit [1:0] cc;
      r  = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 3) != 0);
      ak = $urandom_range(0, 1) != 0;
      rs = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 7))
        0:       cc = 2'b10;
        1, 2:    cc = 2'b00;
        3, 4:    cc = 2'b01;
        default: cc = 2'b11;
      endcase
      step(r, cc, en, ak, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
